// File: rtl/qspi_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : qspi_slave_responder
// Desc     : QSPI flash-style target. Oversamples sclk/cs_n in sys_clk and
//            serves read/write frames through a byte-wide memory port.
//            Define QSPI_SLV_DDR_EN to add cfg_ddr (double-rate data phases).
// Revision : 1.0 - initial release
// ============================================================================
module qspi_slave_responder #(
    parameter int         ADDR_W    = 24,
    parameter logic [7:0] READ_CMD  = 8'h0B,
    parameter logic [7:0] WRITE_CMD = 8'h02
) (
    input  logic              sys_clk,
    input  logic              a_res,
    input  logic              qspi_sclk,
    input  logic              cs_n,
    input  logic [3:0]        qio_in,
    output logic [3:0]        qio_out,
    output logic [3:0]        qio_oe,
    input  logic [1:0]        cfg_cmd_lanes,
    input  logic [1:0]        cfg_addr_lanes,
    input  logic [1:0]        cfg_data_lanes,
    input  logic [1:0]        cfg_addr_bytes,
    input  logic [1:0]        cfg_mode_bytes,
    input  logic [4:0]        cfg_dummy_cycles,
`ifdef QSPI_SLV_DDR_EN
    input  logic              cfg_ddr,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata,
    output logic [3:0]        cur_state,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [3:0] c_IDLE   = 4'd0;
    localparam logic [3:0] c_CMD    = 4'd1;
    localparam logic [3:0] c_ADDR   = 4'd2;
    localparam logic [3:0] c_MODE   = 4'd3;
    localparam logic [3:0] c_DUMMY  = 4'd4;
    localparam logic [3:0] c_RDATA  = 4'd7;
    localparam logic [3:0] c_WDATA  = 4'd8;
    localparam logic [3:0] c_IGNORE = 4'd9;

    function automatic logic [5:0] lane_count(input logic [1:0] code);
        case (code)
            2'd0:    return 6'd1;
            2'd1:    return 6'd2;
            default: return 6'd4;
        endcase
    endfunction

    logic              r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic              r_cs_s1, r_cs_s2, r_cs_d;
    logic [3:0]        r_qio_s1, r_qio_s2;
    logic [3:0]        r_state, w_state_next;
    logic [1:0]        r_cmd_lanes, r_addr_lanes, r_data_lanes;
    logic [1:0]        r_addr_bytes, r_mode_bytes;
    logic [4:0]        r_dummy;
    logic              r_is_read;
    logic [5:0]        r_cnt;
    logic [31:0]       r_in_shift;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_tx_shift;
    logic [5:0]        r_tx_cnt;
    logic              r_rd_d;

    logic              w_rise, w_fall, w_cs_rise, w_cs_fall, w_frame_end;
    logic              w_ddr;
    logic [1:0]        w_rx_lanes;
    logic [5:0]        w_rx_n, w_cnt_next, w_phase_len;
    logic [3:0]        w_rx_in;
    logic [31:0]       w_shift_next;
    logic              w_rx_edge, w_rx_done, w_dummy_done;
    logic [7:0]        w_opcode;
    logic [ADDR_W-1:0] w_addr_cap, w_addr_inc;
    logic [3:0]        w_after_mode, w_after_addr;
    logic [5:0]        w_tx_n, w_tx_cnt_next;
    logic [7:0]        w_tx_src;
    logic [3:0]        w_tx_out;
    logic              w_tx_edge, w_enter_rdata;

    // Sync flops reset to "selected" so a reset mid-frame needs a fresh cs_n fall.
    always_ff @(posedge sys_clk or posedge a_res) begin
        if (a_res) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_cs_s1   <= 1'b0;
            r_cs_s2   <= 1'b0;
            r_cs_d    <= 1'b0;
            r_qio_s1  <= 4'd0;
            r_qio_s2  <= 4'd0;
        end else begin
            r_sclk_s1 <= qspi_sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_cs_s1   <= cs_n;
            r_cs_s2   <= r_cs_s1;
            r_cs_d    <= r_cs_s2;
            r_qio_s1  <= qio_in;
            r_qio_s2  <= r_qio_s1;
        end
    end

    assign w_rise      = r_sclk_s2 & ~r_sclk_d;
    assign w_fall      = ~r_sclk_s2 & r_sclk_d;
    assign w_cs_fall   = ~r_cs_s2 & r_cs_d;
    assign w_cs_rise   = r_cs_s2 & ~r_cs_d;
    assign w_frame_end = w_cs_rise && (r_state != c_IDLE);

`ifdef QSPI_SLV_DDR_EN
    logic r_ddr;
    always_ff @(posedge sys_clk or posedge a_res) begin
        if (a_res) begin
            r_ddr <= 1'b0;
        end else if (r_state == c_IDLE && w_cs_fall) begin
            r_ddr <= cfg_ddr;
        end
    end
    assign w_ddr = r_ddr;
`else
    assign w_ddr = 1'b0;
`endif

    // Receive path shared by CMD, ADDR, MODE and WDATA
    always_comb begin
        w_rx_lanes = r_addr_lanes;
        case (r_state)
            c_CMD:   w_rx_lanes = r_cmd_lanes;
            c_WDATA: w_rx_lanes = r_data_lanes;
            default: w_rx_lanes = r_addr_lanes;
        endcase
    end

    always_comb begin
        w_rx_in = r_qio_s2;
        case (w_rx_lanes)
            2'd0:    w_rx_in = {3'b000, r_qio_s2[0]};
            2'd1:    w_rx_in = {2'b00, r_qio_s2[1:0]};
            default: w_rx_in = r_qio_s2;
        endcase
    end

    always_comb begin
        w_phase_len = 6'd8;
        case (r_state)
            c_ADDR:  w_phase_len = ({4'd0, r_addr_bytes} + 6'd1) << 3;
            c_MODE:  w_phase_len = {4'd0, r_mode_bytes} << 3;
            default: w_phase_len = 6'd8;
        endcase
    end

    assign w_rx_n       = lane_count(w_rx_lanes);
    assign w_shift_next = (r_in_shift << w_rx_n) | {28'd0, w_rx_in};
    assign w_cnt_next   = r_cnt + w_rx_n;
    assign w_rx_edge    = ((r_state == c_CMD) || (r_state == c_ADDR) ||
                           (r_state == c_MODE) || (r_state == c_WDATA)) &&
                          (w_rise || (w_ddr && w_fall && (r_state != c_CMD)));
    assign w_rx_done    = w_rx_edge && (w_cnt_next == w_phase_len);
    assign w_dummy_done = (r_state == c_DUMMY) && w_rise &&
                          ((r_cnt + 6'd1) == {1'b0, r_dummy});
    assign w_opcode     = w_shift_next[7:0];
    assign w_addr_cap   = w_shift_next[ADDR_W-1:0];
    assign w_addr_inc   = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

    assign w_after_mode = !r_is_read         ? c_WDATA :
                          (r_dummy != 5'd0)  ? c_DUMMY : c_RDATA;
    assign w_after_addr = (r_mode_bytes != 2'd0) ? c_MODE : w_after_mode;

    // Transmit path; the just-fetched byte bypasses the shift register
    assign w_tx_n        = lane_count(r_data_lanes);
    assign w_tx_src      = r_rd_d ? mem_rdata : r_tx_shift;
    assign w_tx_cnt_next = r_tx_cnt + w_tx_n;
    assign w_tx_edge     = (r_state == c_RDATA) && !w_cs_rise &&
                           (w_fall || (w_ddr && w_rise));

    always_comb begin
        w_tx_out = w_tx_src[7:4];
        case (r_data_lanes)
            2'd0:    w_tx_out = {2'b00, w_tx_src[7], 1'b0};
            2'd1:    w_tx_out = {2'b00, w_tx_src[7:6]};
            default: w_tx_out = w_tx_src[7:4];
        endcase
    end

    // FSM state register
    always_ff @(posedge sys_clk or posedge a_res) begin
        if (a_res) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        if (w_frame_end) begin
            w_state_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (w_cs_fall) w_state_next = c_CMD;
                c_CMD:   if (w_rx_done) w_state_next =
                             ((w_opcode == READ_CMD) || (w_opcode == WRITE_CMD)) ? c_ADDR : c_IGNORE;
                c_ADDR:  if (w_rx_done) w_state_next = w_after_addr;
                c_MODE:  if (w_rx_done) w_state_next = w_after_mode;
                c_DUMMY: if (w_dummy_done) w_state_next = c_RDATA;
                default: w_state_next = r_state;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        cur_state = r_state;
        busy      = (r_state != c_IDLE);
        qio_oe    = 4'b0000;
        if (r_state == c_RDATA) begin
            case (r_data_lanes)
                2'd0:    qio_oe = 4'b0010;
                2'd1:    qio_oe = 4'b0011;
                default: qio_oe = 4'b1111;
            endcase
        end
    end

    assign w_enter_rdata = (w_state_next == c_RDATA) && (r_state != c_RDATA);

    // Datapath: shifting, address tracking and memory strobes
    always_ff @(posedge sys_clk or posedge a_res) begin
        if (a_res) begin
            r_cmd_lanes  <= 2'd0;
            r_addr_lanes <= 2'd0;
            r_data_lanes <= 2'd0;
            r_addr_bytes <= 2'd0;
            r_mode_bytes <= 2'd0;
            r_dummy      <= 5'd0;
            r_is_read    <= 1'b0;
            r_cnt        <= 6'd0;
            r_in_shift   <= 32'd0;
            r_addr       <= '0;
            r_tx_shift   <= 8'd0;
            r_tx_cnt     <= 6'd0;
            r_rd_d       <= 1'b0;
            qio_out      <= 4'd0;
            mem_addr     <= '0;
            mem_rd_en    <= 1'b0;
            mem_wr_en    <= 1'b0;
            mem_wdata    <= 8'd0;
            frame_done   <= 1'b0;
        end else begin
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            frame_done <= w_frame_end;
            r_rd_d     <= mem_rd_en;
            if (r_state == c_IDLE && w_cs_fall) begin
                r_cmd_lanes  <= cfg_cmd_lanes;
                r_addr_lanes <= cfg_addr_lanes;
                r_data_lanes <= cfg_data_lanes;
                r_addr_bytes <= cfg_addr_bytes;
                r_mode_bytes <= cfg_mode_bytes;
                r_dummy      <= cfg_dummy_cycles;
            end
            if (w_frame_end || r_state == c_IDLE) begin
                r_cnt      <= 6'd0;
                r_in_shift <= 32'd0;
                r_tx_cnt   <= 6'd0;
                qio_out    <= 4'd0;
            end else begin
                if (w_rx_edge) begin
                    r_cnt      <= w_rx_done ? 6'd0  : w_cnt_next;
                    r_in_shift <= w_rx_done ? 32'd0 : w_shift_next;
                end else if (r_state == c_DUMMY && w_rise) begin
                    r_cnt <= w_dummy_done ? 6'd0 : r_cnt + 6'd1;
                end
                if (r_state == c_CMD && w_rx_done) begin
                    r_is_read <= (w_opcode == READ_CMD);
                end
                if (r_state == c_ADDR && w_rx_done) begin
                    r_addr <= w_addr_cap;
                end
                if (w_enter_rdata) begin
                    mem_rd_en <= 1'b1;
                    mem_addr  <= (r_state == c_ADDR) ? w_addr_cap : r_addr;
                end
                if (r_state == c_WDATA && w_rx_done) begin
                    mem_wr_en <= 1'b1;
                    mem_wdata <= w_shift_next[7:0];
                    mem_addr  <= r_addr;
                    r_addr    <= w_addr_inc;
                end
                if (w_tx_edge) begin
                    qio_out    <= w_tx_out;
                    r_tx_shift <= w_tx_src << w_tx_n;
                    if (w_tx_cnt_next == 6'd8) begin
                        r_tx_cnt  <= 6'd0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= w_addr_inc;
                        r_addr    <= w_addr_inc;
                    end else begin
                        r_tx_cnt <= w_tx_cnt_next;
                    end
                end else if (r_rd_d) begin
                    r_tx_shift <= mem_rdata;
                end
                if (r_state != c_RDATA) begin
                    qio_out <= 4'd0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/qspi_slave_responder.md
Name: qspi_slave_responder

Overview:
- QSPI target (flash-style responder): the far end of the link driven by qspi_master; serves as the bench/FPGA-side memory model.
- Oversamples qspi_sclk/cs_n in the sys_clk domain, decodes command, address, mode and dummy phases, then returns read data from a local memory port or accepts write data into it.
- SPI mode 0: samples inputs on sclk rising edges, launches outputs on sclk falling edges; 1, 2 or 4 lanes per phase.

Parameters:
- ADDR_W, 24, memory byte-address width; the address phase keeps the low ADDR_W bits.
- READ_CMD, 8'h0B, opcode selecting the read frame.
- WRITE_CMD, 8'h02, opcode selecting the write frame.

Ports:
- sys_clk  in  1  system clock; qspi_sclk period must be at least 4 sys_clk, high and low phases each at least 2 sys_clk.
- a_res  in  1  reset, asynchronous, active-high.
- qspi_sclk  in  1  serial clock from master.
- cs_n  in  1  chip select from master, active-low.
- qio_in  in  4  lane inputs (master qio_out).
- qio_out  out  4  lane outputs (master qio_in).
- qio_oe  out  4  per-lane output enable.
- cfg_cmd_lanes, cfg_addr_lanes, cfg_data_lanes  in  2 each  0=single, 1=dual, 2=quad; 3 is treated as quad.
- cfg_addr_bytes  in  2  address bytes minus 1 (0..3).
- cfg_mode_bytes  in  2  mode bytes (0..3); mode uses the address lanes.
- cfg_dummy_cycles  in  5  dummy sclk cycles (0..31), read frames only.
- mem_addr  out  ADDR_W  byte address.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_rdata  in  8  read data, valid the cycle after mem_rd_en.
- mem_wr_en  out  1  one-cycle write strobe.
- mem_wdata  out  8  write byte.
- cur_state  out  4  FSM state code.
- busy  out  1  high whenever cur_state != IDLE.
- frame_done  out  1  one-cycle pulse when a frame ends.

Behaviour:
- Synchronisation and edge detect:
  - qspi_sclk, cs_n and qio_in each pass through 2 flops.
  - rise = sync sclk 0->1; fall = sync sclk 1->0.
  - All protocol logic is clocked by sys_clk only.
- Reset values: qio_out=0, qio_oe=0, mem_*=0, cur_state=IDLE(0), busy=0, frame_done=0, all counters 0.
- Lane mapping, MSB first in every case:
  - single: input qio[0], output qio[1].
  - dual: qio[1:0].
  - quad: qio[3:0].
  - Bits per rise = 1/2/4; a byte completes after 8/4/2 edges.
- States: IDLE(0), CMD(1), ADDR(2), MODE(3), DUMMY(4), RDATA(7), WDATA(8), IGNORE(9).
  - IDLE -> CMD on synced cs_n falling edge.
  - CMD: 8 bits on cmd lanes.
    - READ_CMD -> ADDR.
    - WRITE_CMD -> ADDR.
    - any other opcode -> IGNORE.
  - ADDR: (cfg_addr_bytes+1)*8 bits shifted in.
    - Next state: MODE if cfg_mode_bytes != 0; else DUMMY (read, dummy != 0); else RDATA (read); else WDATA (write).
  - MODE: mode bits are consumed and discarded; exits as ADDR does, skipping MODE.
  - DUMMY: counts cfg_dummy_cycles rises, then -> RDATA.
- Read prefetch:
  - On the rise completing the final pre-data phase, issue mem_rd_en with the captured address.
  - Load mem_rdata into the shift register the next cycle.
  - The first data bit is driven on the immediately following fall.
- RDATA:
  - qio_oe = lane mask of cfg_data_lanes; single-lane mode sets 4'b0010.
  - Each fall shifts out the next bits.
  - When a byte's last bits are launched, address+1 is read in prefetch style.
  - The address wraps from 2^ADDR_W-1 to 0.
- WDATA:
  - Bytes are assembled on rises.
  - Each full byte pulses mem_wr_en with mem_wdata and the current address, then the address increments with the same wrap.
  - A partial byte at cs_n deassert is discarded.
- Frame end, from any state:
  - Synced cs_n rising returns the FSM to IDLE in the same cycle.
  - qio_oe=0, frame_done pulses 1 cycle, and no further mem strobes are issued.
  - cs_n rising during CMD/ADDR aborts silently (frame_done still pulses).
- qio_oe is 0 in every state except RDATA.
- cfg_* inputs are sampled at cs_n falling and held for the frame.
- Asynchronous reset mid-frame forces reset values immediately. The next frame starts only after a fresh cs_n falling edge.

Optional Feature:
- QSPI_SLV_DDR_EN defined:
  - adds input cfg_ddr (1 bit, sampled at cs_n fall);
  - when cfg_ddr=1, ADDR, MODE, WDATA and RDATA transfer on both sclk edges: input sampled on rise and fall, output launched on each edge;
  - CMD and DUMMY stay single-rate;
  - the prefetch read is issued on the last address/mode/dummy edge.
- Undefined: the port is absent and all phases are SDR.

Test Plan:
- Quad read: cmd 0x0B on 1 lane, 3-byte address 0xF32579 quad, mode 0x2A, 4 dummy cycles, mem holds 0xA5,0x3C at 0xF32579/0xF3257A -> mem_rd_en at address 0xF32579 then 0xF3257A; qio_out nibbles A,5,3,C; qio_oe=4'hF only during RDATA.
- Single read, 1 dummy cycle, address 0x000010, mem 0x81 -> qio[1] serial 1,0,0,0,0,0,0,1; qio_oe=4'b0010.
- Dual write: cmd 0x02, address 0xFFFFFF, data 0x11,0x22 -> mem_wr_en at 0xFFFFFF (0x11), then 0x000000 (0x22), proving wrap.
- Unknown opcode 0x9F followed by 32 sclk cycles -> state IGNORE, no mem strobes, qio_oe=0, frame_done pulses at cs_n rise.
- cs_n raised mid-RDATA after 3 nibbles -> IDLE next cycle, qio_oe=0, no further mem_rd_en; next frame decodes normally.
- a_res asserted during ADDR -> all outputs 0 immediately; the following full quad read returns correct data.
